// File: rtl/sseg_scan_decoder.sv
// Passive monitor for a multiplexed seven-segment bus: rebuilds hex digits and decimal points per anode slot into frames.
// Define SSEG_ACTIVE_LOW_EN to invert synchronised segment/dp bits for boards with active-low segments.
module sseg_scan_decoder #(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an_i,
  input  logic [7:0]            sseg_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic [DIGITS-1:0]     dp_out_o,
  output logic                  frame_valid_o,
  output logic                  err_o,
  output logic [2:0]            err_digit_o
);

  localparam int unsigned BUS_W = DIGITS + 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_HELD} state_e;

  state_e                state_q, state_d;
  logic [BUS_W-1:0]      sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d, run_c;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d, value_q, value_d;
  logic [DIGITS-1:0]     sdp_q, sdp_d, dp_q, dp_d, seen_q, seen_d;
  logic                  fv_q, fv_d, err_q, err_d;
  logic [IDX_W-1:0]      err_digit_q, err_digit_d;

  logic [DIGITS-1:0]     an_s;
  logic [7:0]            seg_s;
  logic                  changed_c, sel_c, commit_c, frame_done_c, legal_c;
  logic [3:0]            zero_cnt_c, hex_c;
  logic [IDX_W-1:0]      slot_c;

  assign an_s = sync2_q[8 +: DIGITS];
`ifdef SSEG_ACTIVE_LOW_EN
  assign seg_s = ~sync2_q[7:0];
`else
  assign seg_s = sync2_q[7:0];
`endif
  assign changed_c    = (sync2_q != prev_q);
  assign frame_done_c = &seen_q;

  // Returns {legal, hex} for a segment pattern a..g (a at bit 6).
  function automatic logic [4:0] decode7(input logic [6:0] s);
    case (s)
      7'b1111110: decode7 = {1'b1, 4'h0};
      7'b0110000: decode7 = {1'b1, 4'h1};
      7'b1101101: decode7 = {1'b1, 4'h2};
      7'b1111001: decode7 = {1'b1, 4'h3};
      7'b0110011: decode7 = {1'b1, 4'h4};
      7'b1011011: decode7 = {1'b1, 4'h5};
      7'b1011111: decode7 = {1'b1, 4'h6};
      7'b1110000: decode7 = {1'b1, 4'h7};
      7'b1111111: decode7 = {1'b1, 4'h8};
      7'b1111011: decode7 = {1'b1, 4'h9};
      7'b1110111: decode7 = {1'b1, 4'hA};
      7'b0011111: decode7 = {1'b1, 4'hB};
      7'b1001110: decode7 = {1'b1, 4'hC};
      7'b0111101: decode7 = {1'b1, 4'hD};
      7'b1001111: decode7 = {1'b1, 4'hE};
      7'b1000111: decode7 = {1'b1, 4'hF};
      default:    decode7 = 5'b0_0000;
    endcase
  endfunction

  assign {legal_c, hex_c} = decode7(seg_s[6:0]);

  // A slot is selected only when exactly one anode is pulled low.
  always_comb begin
    zero_cnt_c = '0;
    slot_c     = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!an_s[i]) begin
        zero_cnt_c = zero_cnt_c + 4'd1;
        slot_c     = IDX_W'(i);
      end
    end
  end

  assign sel_c = (zero_cnt_c == 4'd1);

  // Dwell tracking: run_c is how many consecutive cycles the current bus value has been seen.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    run_c    = (changed_c || state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    if (!sel_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_HELD && !changed_c) begin
      state_d = ST_HELD;
    end else if (run_c == CNT_W'(STABLE_CYCLES)) begin
      commit_c = 1'b1;
      state_d  = ST_HELD;
      cnt_d    = run_c;
    end else begin
      state_d = ST_TRACK;
      cnt_d   = run_c;
    end
  end

  // Frame assembly; a commit coinciding with the seen clear keeps only its own bit.
  always_comb begin
    shadow_d    = shadow_q;
    sdp_d       = sdp_q;
    seen_d      = frame_done_c ? '0 : seen_q;
    value_d     = value_q;
    dp_d        = dp_q;
    fv_d        = 1'b0;
    err_d       = 1'b0;
    err_digit_d = err_digit_q;
    if (frame_done_c) begin
      value_d = shadow_q;
      dp_d    = sdp_q;
      fv_d    = 1'b1;
    end
    if (commit_c) begin
      if (!legal_c) begin
        err_d       = 1'b1;
        err_digit_d = slot_c;
      end
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (slot_c == IDX_W'(i)) begin
          seen_d[i] = legal_c;
          if (legal_c) begin
            shadow_d[4*i +: 4] = hex_c;
            sdp_d[i]           = seg_s[7];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      sdp_q       <= '0;
      seen_q      <= '0;
      value_q     <= '0;
      dp_q        <= '0;
      fv_q        <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      sync1_q     <= {an_i, sseg_i};
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      sdp_q       <= sdp_d;
      seen_q      <= seen_d;
      value_q     <= value_d;
      dp_q        <= dp_d;
      fv_q        <= fv_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
    end
  end

  assign value_o       = value_q;
  assign dp_out_o      = dp_q;
  assign frame_valid_o = fv_q;
  assign err_o         = err_q;
  assign err_digit_o   = err_digit_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed frame table, corner sequences and random dwells against a dwell-level model.
module tb_sseg_scan_decoder;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned S      = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  an_i = 8'hFF;
  logic [7:0]  sseg_i = 8'h00;
  logic [31:0] value_o;
  logic [7:0]  dp_out_o;
  logic        frame_valid_o, err_o;
  logic [2:0]  err_digit_o;

  always #5 clk = ~clk;

  sseg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .an_i(an_i), .sseg_i(sseg_i),
    .value_o(value_o), .dp_out_o(dp_out_o), .frame_valid_o(frame_valid_o),
    .err_o(err_o), .err_digit_o(err_digit_o)
  );

  int errors = 0;
  int checks = 0;
  int fv_count = 0;
  int err_count = 0;

  logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Dwell-level reference: each dwell of S or more cycles on one slot is a single commit.
  logic [3:0]  m_shadow [8];
  logic [7:0]  m_dp;
  logic [7:0]  m_seen;
  logic [39:0] exp_frames [$];
  int          exp_errs [$];
  int          exp_err_digit = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode_ref(input logic [6:0] s);
    for (int h = 0; h < 16; h++) if (glyph[h] == s) return h;
    return -1;
  endfunction

  function automatic int slot_ref(input logic [7:0] an);
    int zeros = 0;
    int idx = -1;
    for (int i = 0; i < 8; i++) if (!an[i]) begin zeros++; idx = i; end
    return (zeros == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_shadow[i] = 4'h0;
    m_dp = '0;
    m_seen = '0;
    exp_frames.delete();
    exp_errs.delete();
    exp_err_digit = 0;
  endtask

  task automatic model_dwell(input logic [7:0] an, input logic [7:0] seg, input int len);
    int k, h;
    logic [39:0] f;
    k = slot_ref(an);
    if (k < 0 || len < int'(S)) return;
    h = decode_ref(seg[6:0]);
    if (h >= 0) begin
      m_shadow[k] = 4'(h);
      m_dp[k] = seg[7];
      m_seen[k] = 1'b1;
      if (&m_seen) begin
        for (int i = 0; i < 8; i++) f[4*i +: 4] = m_shadow[i];
        f[39:32] = m_dp;
        exp_frames.push_back(f);
        m_seen = '0;
      end
    end else begin
      exp_errs.push_back(k);
      m_seen[k] = 1'b0;
    end
  endtask

  task automatic dwell(input logic [7:0] an, input logic [7:0] seg, input int len);
    an_i = an;
`ifdef SSEG_ACTIVE_LOW_EN
    sseg_i = ~seg;
`else
    sseg_i = seg;
`endif
    model_dwell(an, seg, len);
    repeat (len) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    dwell(8'hFF, 8'h00, n);
  endtask

  function automatic logic [7:0] an_of(input int i);
    logic [7:0] one = 8'h01;
    return ~(one << i);
  endfunction

  task automatic scan(input logic [31:0] nibbles, input logic [7:0] dps, input int first, input int last);
    for (int i = first; i <= last; i++) dwell(an_of(i), {dps[i], glyph[nibbles[4*i +: 4]]}, 6);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_value"}, 64'(value_o), 64'd0);
    check({tag, "_dp"}, 64'(dp_out_o), 64'd0);
    check({tag, "_frame_valid"}, 64'(frame_valid_o), 64'd0);
    check({tag, "_err"}, 64'(err_o), 64'd0);
    check({tag, "_err_digit"}, 64'(err_digit_o), 64'd0);
  endtask

  // Output monitor on the falling edge, matching DUT events against model queues.
  initial begin
    logic [39:0] f;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_valid_o) begin
          fv_count++;
          if (exp_frames.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_valid: unexpected pulse, value 0x%0h, none required", value_o);
          end else begin
            f = exp_frames.pop_front();
            check("frame_value", 64'(value_o), 64'(f[31:0]));
            check("frame_dp", 64'(dp_out_o), 64'(f[39:32]));
          end
        end
        if (err_o) begin
          err_count++;
          if (exp_errs.size() == 0) begin
            checks++; errors++;
            $display("FAIL err: unexpected pulse on digit %0d, none required", err_digit_o);
          end else begin
            exp_err_digit = exp_errs.pop_front();
          end
        end
        check("err_digit_hold", 64'(err_digit_o), 64'(exp_err_digit));
      end
    end
  end

  typedef struct {
    logic [31:0] nibbles;
    logic [7:0]  dps;
    logic [31:0] exp_value;
    logic [7:0]  exp_dp;
  } frame_vec_t;

  initial begin
    frame_vec_t vecs [3];
    int fv0, e0;
    logic [15:0] prev;
    logic [7:0] an, seg;
    int r, len, a, b;

    vecs[0] = '{32'h87654321, 8'h01, 32'h87654321, 8'h01};
    vecs[1] = '{32'h09ABCDEF, 8'h00, 32'h09ABCDEF, 8'h00};
    vecs[2] = '{32'h13579BDF, 8'hA5, 32'h13579BDF, 8'hA5};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 3; v++) begin
      fv0 = fv_count; e0 = err_count;
      scan(vecs[v].nibbles, vecs[v].dps, 0, 7);
      idle(10);
      check("table_frame_count", 64'(fv_count - fv0), 64'd1);
      check("table_value", 64'(value_o), 64'(vecs[v].exp_value));
      check("table_dp", 64'(dp_out_o), 64'(vecs[v].exp_dp));
      check("table_no_err", 64'(err_count - e0), 64'd0);
    end

    // Digit 3 never dwells long enough to commit.
    fv0 = fv_count;
    scan(32'h87654321, 8'h00, 0, 2);
    dwell(an_of(3), {1'b0, glyph[5]}, 3);
    dwell(an_of(3), {1'b0, glyph[6]}, 3);
    idle(2);
    scan(32'h87654321, 8'h00, 4, 7);
    idle(10);
    check("glitch_no_frame", 64'(fv_count - fv0), 64'd0);
    scan(32'h87654321, 8'h00, 3, 3);
    idle(10);
    check("glitch_then_frame", 64'(fv_count - fv0), 64'd1);
    check("glitch_value", 64'(value_o), 64'h87654321);

    // Blank pattern on digit 5 is illegal and blocks the frame.
    fv0 = fv_count; e0 = err_count;
    scan(32'h11111111, 8'h00, 0, 4);
    scan(32'h11111111, 8'h00, 6, 7);
    dwell(an_of(5), 8'h00, 5);
    idle(10);
    check("illegal_err_count", 64'(err_count - e0), 64'd1);
    check("illegal_err_digit", 64'(err_digit_o), 64'd5);
    check("illegal_no_frame", 64'(fv_count - fv0), 64'd0);
    scan(32'h22222222, 8'h20, 5, 5);
    idle(10);
    check("illegal_then_frame", 64'(fv_count - fv0), 64'd1);
    check("illegal_value", 64'(value_o), 64'h11211111);
    check("illegal_dp", 64'(dp_out_o), 64'h20);

    // Two anodes low selects no slot.
    fv0 = fv_count; e0 = err_count;
    dwell(8'hFC, {1'b0, glyph[8]}, 10);
    scan(32'h76543210, 8'h00, 1, 7);
    idle(10);
    check("multi_an_no_frame", 64'(fv_count - fv0), 64'd0);
    check("multi_an_no_err", 64'(err_count - e0), 64'd0);
    scan(32'h76543210, 8'h00, 0, 0);
    idle(10);
    check("multi_an_then_frame", 64'(fv_count - fv0), 64'd1);
    check("multi_an_value", 64'(value_o), 64'h76543210);

    // Reset mid-scan discards the partial frame.
    scan(32'h44444444, 8'h00, 0, 3);
    dwell(an_of(4), {1'b0, glyph[4]}, 3);
    rst_n = 1'b0;
    an_i = 8'hFF;
    model_reset();
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fv0 = fv_count;
    scan(32'h0000CAFE, 8'h80, 0, 6);
    idle(10);
    check("reset_no_early_frame", 64'(fv_count - fv0), 64'd0);
    scan(32'h0000CAFE, 8'h80, 7, 7);
    idle(10);
    check("reset_frame", 64'(fv_count - fv0), 64'd1);
    check("reset_value", 64'(value_o), 64'h0000CAFE);

    // Random dwells against the model; consecutive dwells always differ.
    prev = {8'hFF, 8'h00};
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) an = 8'hFF;
      else if (r == 1) begin
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        an = an_of(a) & an_of(b);
      end else an = an_of($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) seg[6:0] = 7'($urandom_range(0, 127));
      else seg[6:0] = glyph[$urandom_range(0, 15)];
      seg[7] = 1'($urandom_range(0, 1));
      if ({an, seg} == prev) seg[7] = ~seg[7];
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 8);
      dwell(an, seg, len);
      prev = {an, seg};
    end
    idle(20);
    check("random_frames_drained", 64'(exp_frames.size()), 64'd0);
    check("random_errs_drained", 64'(exp_errs.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
